// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pkg
// Purpose  : Shared sizes, status/op encodings and FSM states for cam_writer.
// Revision : 1.0
// ============================================================================
package cam_pkg;

   localparam int DEPTH   = 32;
   localparam int AW      = 5;
   localparam int KW      = 8;
   localparam int CAM_LAT = 1;

   typedef enum logic [1:0] {
      RSP_OK       = 2'd0,
      RSP_DUP      = 2'd1,
      RSP_FULL     = 2'd2,
      RSP_NOTFOUND = 2'd3
   } status_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEARCH = 3'd1,
      ST_CHECK  = 3'd2,
      ST_WRITE  = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

   typedef enum logic {
      OP_INSERT = 1'b0,
      OP_DELETE = 1'b1
   } op_e;

endpackage
`default_nettype wire

// File: rtl/cam_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : cam_writer_if
// Purpose  : Request/response handshake plus CAM write/search port bundle.
// Revision : 1.0
// ============================================================================
interface cam_writer_if
   import cam_pkg::*;
#(
   parameter int AW = cam_pkg::AW,
   parameter int KW = cam_pkg::KW
);
   logic          req_valid;
   logic          req_ready;
   logic          req_op;
   logic [KW-1:0] req_key;
   logic [AW-1:0] req_addr;
   logic          rsp_valid;
   logic [AW-1:0] rsp_addr;
   logic [1:0]    rsp_status;
   logic          cam_enable;
   logic          cam_write;
   logic [AW-1:0] cam_addr;
   logic [KW-1:0] cam_data;
   logic [AW-1:0] cam_out;

   modport master (
      output req_valid, req_op, req_key, req_addr, cam_out,
      input  req_ready, rsp_valid, rsp_addr, rsp_status,
             cam_enable, cam_write, cam_addr, cam_data
   );

   modport slave (
      input  req_valid, req_op, req_key, req_addr, cam_out,
      output req_ready, rsp_valid, rsp_addr, rsp_status,
             cam_enable, cam_write, cam_addr, cam_data
   );
endinterface
`default_nettype wire

// File: rtl/cam_free_enc.sv
`default_nettype none
// ============================================================================
// Module   : cam_free_enc
// Purpose  : Lowest-zero priority encoder over the occupancy bitmap.
// Revision : 1.0
// ============================================================================
module cam_free_enc
   import cam_pkg::*;
#(
   parameter int DEPTH = cam_pkg::DEPTH,
   parameter int AW    = cam_pkg::AW
) (
   input  logic [DEPTH-1:0] occ,
   output logic [AW-1:0]    idx,
   output logic             none_free
);
   always_comb begin
      idx       = '0;
      none_free = &occ;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!occ[i]) idx = AW'(i);
      end
   end
endmodule
`default_nettype wire

// File: rtl/cam_writer.sv
`default_nettype none
// ============================================================================
// Module   : cam_writer
// Purpose  : Serialised insert/delete front-end that allocates and writes CAM
//            slots. CAM_WRITER_DUP_CHECK_EN adds a search-before-insert step.
// Revision : 1.0
// ============================================================================
module cam_writer
   import cam_pkg::*;
#(
   parameter int DEPTH = cam_pkg::DEPTH,
   parameter int AW    = cam_pkg::AW,
   parameter int KW    = cam_pkg::KW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   cam_writer_if.slave  bus,
   output logic [AW:0]  count,
   output logic         full
);
   localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

   state_e          r_state, w_state;
   logic [DEPTH-1:0] r_occ, w_occ;
   logic [AW:0]     r_count, w_count;
   logic            r_full;
   logic [KW-1:0]   r_key, w_key;
   logic            r_req_ready, w_req_ready;
   logic            r_rsp_valid, w_rsp_valid;
   logic [AW-1:0]   r_rsp_addr, w_rsp_addr;
   status_e         r_rsp_status, w_rsp_status;
   logic            r_cam_enable;
   logic            r_cam_write, w_cam_write;
   logic [AW-1:0]   r_cam_addr, w_cam_addr;
   logic [KW-1:0]   r_cam_data, w_cam_data;
   logic            w_accept, w_do_write;
   logic [AW-1:0]   w_free_idx;
   logic            w_none_free;

`ifdef CAM_WRITER_DUP_CHECK_EN
   localparam int WAIT_W = $clog2(CAM_LAT + 1);
   logic [WAIT_W-1:0] r_wait, w_wait;
   logic [KW-1:0]     r_shadow [DEPTH];
   logic              w_shadow_we;
`endif

   cam_free_enc #(.DEPTH(DEPTH), .AW(AW)) u_free_enc (
      .occ       (r_occ),
      .idx       (w_free_idx),
      .none_free (w_none_free)
   );

   always_comb begin
      w_state      = r_state;
      w_occ        = r_occ;
      w_count      = r_count;
      w_key        = r_key;
      w_req_ready  = 1'b0;
      w_rsp_valid  = r_rsp_valid;
      w_rsp_addr   = r_rsp_addr;
      w_rsp_status = r_rsp_status;
      w_cam_write  = 1'b0;
      w_cam_addr   = r_cam_addr;
      w_cam_data   = r_cam_data;
      w_do_write   = 1'b0;
`ifdef CAM_WRITER_DUP_CHECK_EN
      w_wait       = r_wait;
      w_shadow_we  = 1'b0;
`endif
      // req_ready is registered, so a handshake it advertised is honoured
      // even if enable drops on the same edge.
      w_accept = (r_state == ST_IDLE) && bus.req_valid && r_req_ready;

      if (enable || w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  w_key = bus.req_key;
                  if (bus.req_op == OP_DELETE) begin
                     w_state     = ST_RESP;
                     w_rsp_valid = 1'b1;
                     w_rsp_addr  = bus.req_addr;
                     if (r_occ[bus.req_addr]) begin
                        w_occ[bus.req_addr] = 1'b0;
                        w_count             = r_count - 1'b1;
                        w_rsp_status        = RSP_OK;
                     end else begin
                        w_rsp_status = RSP_NOTFOUND;
                     end
                  end else begin
`ifdef CAM_WRITER_DUP_CHECK_EN
                     w_state    = ST_SEARCH;
                     w_cam_data = bus.req_key;
                     w_wait     = WAIT_W'(CAM_LAT - 1);
`else
                     w_do_write = 1'b1;
`endif
                  end
               end
            end
`ifdef CAM_WRITER_DUP_CHECK_EN
            ST_SEARCH: begin
               if (r_wait == '0) w_state = ST_CHECK;
               else              w_wait  = r_wait - 1'b1;
            end
            ST_CHECK: begin
               // The CAM may still hold keys of deleted slots; occ masks them.
               if (r_occ[bus.cam_out] && (r_shadow[bus.cam_out] == r_key)) begin
                  w_state      = ST_RESP;
                  w_rsp_valid  = 1'b1;
                  w_rsp_status = RSP_DUP;
                  w_rsp_addr   = bus.cam_out;
               end else if (w_none_free) begin
                  w_state      = ST_RESP;
                  w_rsp_valid  = 1'b1;
                  w_rsp_status = RSP_FULL;
                  w_rsp_addr   = '0;
               end else begin
                  w_do_write = 1'b1;
               end
            end
`endif
            ST_WRITE: begin
               w_state     = ST_RESP;
               w_rsp_valid = 1'b1;
            end
            ST_RESP: begin
               w_state     = ST_IDLE;
               w_rsp_valid = 1'b0;
            end
            default: w_state = ST_IDLE;
         endcase

         if (w_do_write) begin
            w_state = ST_WRITE;
            if (w_none_free) begin
               w_rsp_status = RSP_FULL;
               w_rsp_addr   = '0;
            end else begin
               w_cam_write          = 1'b1;
               w_cam_addr           = w_free_idx;
               w_cam_data           = w_key;
               w_occ[w_free_idx]    = 1'b1;
               w_count              = r_count + 1'b1;
               w_rsp_status         = RSP_OK;
               w_rsp_addr           = w_free_idx;
`ifdef CAM_WRITER_DUP_CHECK_EN
               w_shadow_we          = 1'b1;
`endif
            end
         end
         w_req_ready = enable && (w_state == ST_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_occ        <= '0;
         r_count      <= '0;
         r_full       <= 1'b0;
         r_key        <= '0;
         r_req_ready  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_addr   <= '0;
         r_rsp_status <= RSP_OK;
         r_cam_enable <= 1'b0;
         r_cam_write  <= 1'b0;
         r_cam_addr   <= '0;
         r_cam_data   <= '0;
`ifdef CAM_WRITER_DUP_CHECK_EN
         r_wait       <= '0;
`endif
      end else begin
         r_state      <= w_state;
         r_occ        <= w_occ;
         r_count      <= w_count;
         r_full       <= (w_count == C_DEPTH);
         r_key        <= w_key;
         r_req_ready  <= w_req_ready;
         r_rsp_valid  <= w_rsp_valid;
         r_rsp_addr   <= w_rsp_addr;
         r_rsp_status <= w_rsp_status;
         r_cam_enable <= enable;
         r_cam_write  <= w_cam_write;
         r_cam_addr   <= w_cam_addr;
         r_cam_data   <= w_cam_data;
`ifdef CAM_WRITER_DUP_CHECK_EN
         r_wait       <= w_wait;
`endif
      end
   end

`ifdef CAM_WRITER_DUP_CHECK_EN
   always_ff @(posedge clk) begin
      if (w_shadow_we) r_shadow[w_free_idx] <= w_key;
   end
`endif

   assign bus.req_ready  = r_req_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_addr   = r_rsp_addr;
   assign bus.rsp_status = r_rsp_status;
   assign bus.cam_enable = r_cam_enable;
   assign bus.cam_write  = r_cam_write;
   assign bus.cam_addr   = r_cam_addr;
   assign bus.cam_data   = r_cam_data;
   assign count          = r_count;
   assign full           = r_full;
endmodule
`default_nettype wire
